// File: rtl/stmm_sched_if.sv
// Bundle between stmm_sched and its environment: load/execute requests and
// completions in, fetch control, per-sub exec pulses and status out.
interface stmm_sched_if #(
   parameter int unsigned SUB_NUM = 4,
   parameter int unsigned ADDR_W  = 32
);
   localparam int unsigned IDX_W = (SUB_NUM > 1) ? $clog2(SUB_NUM) : 1;
   localparam int unsigned CNT_W = 32;

   logic [SUB_NUM-1:0]        fetch_req;
   logic [SUB_NUM*ADDR_W-1:0] fetch_addr_in;
   logic [SUB_NUM-1:0]        exec_req;
   logic                      fetch_start;
   logic [IDX_W-1:0]          fetch_sub_idx;
   logic [ADDR_W-1:0]         fetch_addr;
   logic                      fetch_done;
   logic [SUB_NUM-1:0]        exec;
   logic [SUB_NUM-1:0]        exec_done;
   logic [SUB_NUM-1:0]        sub_ready;
   logic                      fetch_busy;
   logic                      err;
   logic [SUB_NUM*CNT_W-1:0]  busy_cycles;

   modport master (
      output fetch_req, fetch_addr_in, exec_req, fetch_done, exec_done,
      input  fetch_start, fetch_sub_idx, fetch_addr, exec, sub_ready,
             fetch_busy, err, busy_cycles
   );

   modport slave (
      input  fetch_req, fetch_addr_in, exec_req, fetch_done, exec_done,
      output fetch_start, fetch_sub_idx, fetch_addr, exec, sub_ready,
             fetch_busy, err, busy_cycles
   );
endinterface

// File: rtl/stmm_sched.sv
// Scheduler for SUB_NUM StMM sub-units: round-robin shared param fetch plus per-sub exec control.
// Define STMM_SCHED_PERF_CNT_EN to build the per-sub EXEC cycle counters on busy_cycles.
module stmm_sched #(
   parameter int unsigned SUB_NUM = 4,
   parameter int unsigned ADDR_W  = 32
) (
   input logic         clk,
   input logic         rst,
   stmm_sched_if.slave bus
);
   localparam int unsigned IDX_W = (SUB_NUM > 1) ? $clog2(SUB_NUM) : 1;
   localparam int unsigned CNT_W = 32;

   typedef enum logic [1:0] {ST_EMPTY, ST_LOADING, ST_READY, ST_EXEC} sub_st_t;

   sub_st_t            st        [SUB_NUM];
   sub_st_t            st_nxt    [SUB_NUM];
   logic [ADDR_W-1:0]  pend_addr [SUB_NUM];
   logic [ADDR_W-1:0]  req_addr  [SUB_NUM];
   logic [SUB_NUM-1:0] pending;
   logic [SUB_NUM-1:0] eligible;
   logic [SUB_NUM-1:0] gnt_vec;
   logic [SUB_NUM-1:0] acc_vec;
   logic [SUB_NUM-1:0] rej_vec;
   logic [SUB_NUM-1:0] done_vec;
   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   grant_idx;
   logic [IDX_W-1:0]   cand;
   logic               grant;
   int unsigned        pos;

   // A same-cycle fetch_req counts as pending; a READY sub with exec_req defers its fetch to the exec.
   always_comb begin
      for (int i = 0; i < SUB_NUM; i++) begin
         req_addr[i] = bus.fetch_req[i] ? bus.fetch_addr_in[i*ADDR_W +: ADDR_W] : pend_addr[i];
         eligible[i] = (pending[i] | bus.fetch_req[i]) &&
                       ((st[i] == ST_EMPTY) || ((st[i] == ST_READY) && !bus.exec_req[i]));
      end
   end

   // Round-robin search starting at rr_ptr; only while the fetcher is idle.
   always_comb begin
      grant     = 1'b0;
      grant_idx = '0;
      pos       = 0;
      cand      = '0;
      for (int unsigned k = 0; k < SUB_NUM; k++) begin
         pos = 32'(rr_ptr) + k;
         if (pos >= SUB_NUM) pos = pos - SUB_NUM;
         cand = IDX_W'(pos);
         if (!grant && !bus.fetch_busy && eligible[cand]) begin
            grant     = 1'b1;
            grant_idx = cand;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < SUB_NUM; i++) begin
         gnt_vec[i]  = grant && (grant_idx == IDX_W'(i));
         done_vec[i] = bus.fetch_done && bus.fetch_busy && (bus.fetch_sub_idx == IDX_W'(i));
         acc_vec[i]  = bus.exec_req[i] && (st[i] == ST_READY) && !gnt_vec[i];
         rej_vec[i]  = bus.exec_req[i] && !acc_vec[i];
         st_nxt[i]   = st[i];
         case (st[i])
            ST_EMPTY:   if (gnt_vec[i]) st_nxt[i] = ST_LOADING;
            ST_LOADING: if (done_vec[i]) st_nxt[i] = ST_READY;
            ST_READY: begin
               if (gnt_vec[i])      st_nxt[i] = ST_LOADING;
               else if (acc_vec[i]) st_nxt[i] = ST_EXEC;
            end
            ST_EXEC:    if (bus.exec_done[i]) st_nxt[i] = ST_READY;
            default:    st_nxt[i] = ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pending           <= '0;
         rr_ptr            <= '0;
         bus.fetch_start   <= 1'b0;
         bus.fetch_sub_idx <= '0;
         bus.fetch_addr    <= '0;
         bus.fetch_busy    <= 1'b0;
         bus.exec          <= '0;
         bus.sub_ready     <= '0;
         bus.err           <= 1'b0;
         for (int i = 0; i < SUB_NUM; i++) begin
            st[i]        <= ST_EMPTY;
            pend_addr[i] <= '0;
         end
      end else begin
         bus.fetch_start <= grant;
         bus.exec        <= acc_vec;
         bus.err         <= |rej_vec;
         if (grant) begin
            bus.fetch_sub_idx <= grant_idx;
            bus.fetch_addr    <= req_addr[grant_idx];
            bus.fetch_busy    <= 1'b1;
            rr_ptr            <= (32'(grant_idx) + 32'd1 >= SUB_NUM) ? '0 : grant_idx + IDX_W'(1);
         end else if (done_vec != '0) begin
            bus.fetch_busy <= 1'b0;
         end
         for (int i = 0; i < SUB_NUM; i++) begin
            st[i]            <= st_nxt[i];
            bus.sub_ready[i] <= (st_nxt[i] == ST_READY);
            if (bus.fetch_req[i]) pend_addr[i] <= bus.fetch_addr_in[i*ADDR_W +: ADDR_W];
            if (gnt_vec[i])            pending[i] <= 1'b0;
            else if (bus.fetch_req[i]) pending[i] <= 1'b1;
         end
      end
   end

`ifdef STMM_SCHED_PERF_CNT_EN
   logic [CNT_W-1:0] cnt [SUB_NUM];

   // Saturating count of cycles spent in EXEC.
   always_ff @(posedge clk) begin
      for (int i = 0; i < SUB_NUM; i++) begin
         if (rst)                                   cnt[i] <= '0;
         else if ((st[i] == ST_EXEC) && (cnt[i] != '1)) cnt[i] <= cnt[i] + CNT_W'(1);
      end
   end

   for (genvar g = 0; g < SUB_NUM; g++) begin : g_cnt
      assign bus.busy_cycles[g*CNT_W +: CNT_W] = cnt[g];
   end
`else
   assign bus.busy_cycles = '0;
`endif
endmodule
